// File: rtl/cu_fsm_mc.sv
// cu_fsm_mc -- multicycle control unit for the OTTER RV32I core.
//
// Sequences INIT -> FETCH -> EXEC -> (WB) -> (INTR) -> FETCH and drives the
// datapath strobes from the present state, the wait counter and the decoded
// opcode/funct3. Instruction-fetch and load latencies are set by parameters.
//
// Parameters:
//   FETCH_WAIT  extra instruction-memory wait cycles (0..15)
//   LOAD_LAT    cycles from load issue to valid load data (1..16)
//   INTR_EN     non-zero enables interrupt entry
//
// Ports:
//   clk        system clock
//   RST        asynchronous active-high reset
//   INTR       level interrupt request (already gated by MIE)
//   opcode     instruction [6:0]
//   funct3     instruction [14:12]
//   PCWrite    PC load enable
//   regWrite   register-file write enable
//   memWE2     data-memory write enable
//   memRDEN1   instruction-memory read enable
//   memRDEN2   data-memory read enable
//   reset      reset request to PC and datapath
//   csr_WE     CSR write enable
//   int_taken  interrupt entry (PC <- mtvec, save mepc)
//   mret_exec  mret execution (PC <- mepc)
//   state      debug state code (INIT=0 FETCH=1 EXEC=2 WB=3 INTR=4)
module cu_fsm_mc #(
    parameter int FETCH_WAIT = 0,
    parameter int LOAD_LAT   = 1,
    parameter int INTR_EN    = 1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       INTR,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic       PCWrite,
    output logic       regWrite,
    output logic       memWE2,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       reset,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec,
    output logic [2:0] state
);

    localparam int MAX_WAIT = (FETCH_WAIT > LOAD_LAT) ? FETCH_WAIT : LOAD_LAT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    // Last-cycle compare values, pre-sized to the counter width.
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_WAIT);
    localparam logic [CNT_W-1:0] WB_LAST    = CNT_W'(LOAD_LAT - 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             intr_req;

    assign intr_req = (INTR_EN != 0) && INTR;
    assign state    = state_reg;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        PCWrite    = 1'b0;
        regWrite   = 1'b0;
        memWE2     = 1'b0;
        memRDEN1   = 1'b0;
        memRDEN2   = 1'b0;
        reset      = 1'b0;
        csr_WE     = 1'b0;
        int_taken  = 1'b0;
        mret_exec  = 1'b0;

        case (state_reg)
            ST_INIT: begin
                reset      = 1'b1;
                state_next = ST_FETCH;
            end

            ST_FETCH: begin
                memRDEN1 = 1'b1;
                if (cnt_reg == FETCH_LAST)
                    state_next = ST_EXEC;
            end

            ST_EXEC: begin
                // Every non-load retires here, so INTR is sampled here too.
                state_next = intr_req ? ST_INTR : ST_FETCH;
                case (opcode)
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_RTYPE, OP_ITYPE: begin
                        regWrite = 1'b1;
                        PCWrite  = 1'b1;
                    end
                    OP_STORE: begin
                        memWE2  = 1'b1;
                        PCWrite = 1'b1;
                    end
                    OP_LOAD: begin
                        // PC advances at the end of WB, not here.
                        memRDEN2   = 1'b1;
                        state_next = ST_WB;
                    end
                    OP_SYS: begin
                        PCWrite = 1'b1;
                        if (funct3 == 3'b000) begin
                            mret_exec = 1'b1;
                        end else if (funct3 == 3'b001 || funct3 == 3'b010 ||
                                     funct3 == 3'b011) begin
                            regWrite = 1'b1;
                            csr_WE   = 1'b1;
                        end
                    end
                    // Branches and unrecognised opcodes just advance the PC,
                    // so illegal instructions are skipped.
                    default: PCWrite = 1'b1;
                endcase
            end

            ST_WB: begin
                if (cnt_reg == WB_LAST) begin
                    PCWrite    = 1'b1;
                    regWrite   = 1'b1;
                    state_next = intr_req ? ST_INTR : ST_FETCH;
                end else begin
                    memRDEN2 = 1'b1;
                end
            end

            ST_INTR: begin
                int_taken  = 1'b1;
                PCWrite    = 1'b1;
                state_next = ST_FETCH;
            end

            default: state_next = ST_FETCH;
        endcase

        // The counter measures time spent in the present state only.
        if (state_next != state_reg)
            cnt_next = '0;
        else
            cnt_next = cnt_reg + CNT_W'(1);
    end

endmodule
